// File: rtl/oled_pkg.sv
// Shared OLED subsystem definitions: arbiter states, SSD1306 command bytes and
// inter-byte gap limits.
package oled_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    localparam logic [7:0] CMD_DISPLAY_OFF    = 8'hAE;
    localparam logic [7:0] CMD_DISPLAY_ON     = 8'hAF;
    localparam logic [7:0] CMD_CHARGE_PUMP    = 8'h8D;
    localparam logic [7:0] CMD_CHARGE_PUMP_ON = 8'h14;
    localparam logic [7:0] CMD_CONTRAST       = 8'h81;

    localparam int IDLE_GAP_MIN = 2;
    localparam int GAP_CNT_W    = 4;

endpackage

// File: rtl/oled_spi_arbiter_if.sv
// Requester/SpiCtrl bundle of the OLED SPI arbiter. The slave side is the
// arbiter; the master side is the requesters plus SpiCtrl's SPI_FIN.
interface oled_spi_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   last;
    logic [NREQ-1:0]   dc_in;
    logic [8*NREQ-1:0] data_in;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic              spi_en;
    logic [7:0]        spi_data;
    logic              spi_fin;
    logic              dc;
    logic              busy;

    modport master (
        output req, last, dc_in, data_in, spi_fin,
        input  gnt, ack, spi_en, spi_data, dc, busy
    );

    modport slave (
        input  req, last, dc_in, data_in, spi_fin,
        output gnt, ack, spi_en, spi_data, dc, busy
    );
endinterface

// File: rtl/oled_spi_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index at or above ptr,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [IW-1:0]   win_idx
);

    logic          found_s;
    logic [IW:0]   sum_s;
    logic [IW-1:0] cand_s;

    // Walk candidates from ptr upward; the first hit wins.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found_s = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s  = {1'b0, ptr} + (IW+1)'(k);
            cand_s = (sum_s >= (IW+1)'(NREQ)) ? IW'(sum_s - (IW+1)'(NREQ)) : IW'(sum_s);
            if (!found_s && req[cand_s]) begin
                found_s         = 1'b1;
                win_oh[cand_s]  = 1'b1;
                win_idx         = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/oled_spi_arbiter.sv
// Round-robin, burst-holding arbiter sharing one SpiCtrl byte engine between
// the OLED init sequencer, frame writer and runtime command port.
module oled_spi_arbiter
    import oled_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int IDLE_GAP = 2
) (
    input  logic               clk,
    input  logic               rst,
    oled_spi_arbiter_if.slave  bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(IDLE_GAP - 1);
    localparam logic [IW-1:0]        LAST_IDX = IW'(NREQ - 1);

    arb_state_e            state_r, state_nxt_s;
    logic [NREQ-1:0]       gnt_r, gnt_nxt_s;
    logic [NREQ-1:0]       ack_r, ack_nxt_s;
    logic [NREQ-1:0]       win_oh_s;
    logic [IW-1:0]         g_idx_r, g_idx_nxt_s;
    logic [IW-1:0]         ptr_r, ptr_nxt_s;
    logic [IW-1:0]         win_idx_s;
    logic [7:0]            spi_data_r, spi_data_nxt_s;
    logic                  dc_r, dc_nxt_s;
    logic                  last_q_r, last_q_nxt_s;
    logic                  spi_en_r, spi_en_nxt_s;
    logic                  busy_r, busy_nxt_s;
    logic [GAP_CNT_W-1:0]  gap_cnt_r, gap_cnt_nxt_s;
    logic [7:0]            byte_s [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_bytes
        assign byte_s[i] = bus.data_in[8*i +: 8];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (bus.req),
        .ptr     (ptr_r),
        .win_oh  (win_oh_s),
        .win_idx (win_idx_s)
    );

    // Next-state and next-output logic; outputs are registered so every port
    // reflects the state it belongs to.
    always_comb begin
        state_nxt_s    = state_r;
        gnt_nxt_s      = gnt_r;
        g_idx_nxt_s    = g_idx_r;
        ptr_nxt_s      = ptr_r;
        ack_nxt_s      = '0;
        spi_en_nxt_s   = 1'b0;
        spi_data_nxt_s = spi_data_r;
        dc_nxt_s       = dc_r;
        last_q_nxt_s   = last_q_r;
        gap_cnt_nxt_s  = gap_cnt_r;
        busy_nxt_s     = 1'b1;
        case (state_r)
            IDLE: begin
                if (|bus.req) begin
                    state_nxt_s    = SEND;
                    gnt_nxt_s      = win_oh_s;
                    g_idx_nxt_s    = win_idx_s;
                    spi_data_nxt_s = byte_s[win_idx_s];
                    dc_nxt_s       = bus.dc_in[win_idx_s];
                    last_q_nxt_s   = bus.last[win_idx_s];
                    spi_en_nxt_s   = 1'b1;
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            SEND: begin
                if (bus.spi_fin) begin
                    state_nxt_s   = GAP;
                    ack_nxt_s     = gnt_r;
                    gap_cnt_nxt_s = '0;
                end else begin
                    spi_en_nxt_s = 1'b1;
                end
            end
            GAP: begin
                // Burst continues only while the owner still requests and the
                // byte just sent was not flagged last.
                if (gap_cnt_r == GAP_LAST) begin
                    if (last_q_r || !bus.req[g_idx_r]) begin
                        state_nxt_s = IDLE;
                        gnt_nxt_s   = '0;
                        ptr_nxt_s   = (g_idx_r == LAST_IDX) ? '0 : g_idx_r + 1'b1;
                        busy_nxt_s  = 1'b0;
                    end else begin
                        state_nxt_s    = SEND;
                        spi_data_nxt_s = byte_s[g_idx_r];
                        dc_nxt_s       = bus.dc_in[g_idx_r];
                        last_q_nxt_s   = bus.last[g_idx_r];
                        spi_en_nxt_s   = 1'b1;
                    end
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r + 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                gnt_nxt_s   = '0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            gnt_r      <= '0;
            g_idx_r    <= '0;
            ptr_r      <= '0;
            ack_r      <= '0;
            spi_en_r   <= 1'b0;
            spi_data_r <= 8'h00;
            dc_r       <= 1'b0;
            last_q_r   <= 1'b0;
            gap_cnt_r  <= '0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            gnt_r      <= gnt_nxt_s;
            g_idx_r    <= g_idx_nxt_s;
            ptr_r      <= ptr_nxt_s;
            ack_r      <= ack_nxt_s;
            spi_en_r   <= spi_en_nxt_s;
            spi_data_r <= spi_data_nxt_s;
            dc_r       <= dc_nxt_s;
            last_q_r   <= last_q_nxt_s;
            gap_cnt_r  <= gap_cnt_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    assign bus.gnt      = gnt_r;
    assign bus.ack      = ack_r;
    assign bus.spi_en   = spi_en_r;
    assign bus.spi_data = spi_data_r;
    assign bus.dc       = dc_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Directed bench for oled_spi_arbiter: single-byte vector table plus burst,
// preemption, drop and reset sequences against a small SpiCtrl/requester model.
module tb_oled_spi_arbiter;
    import oled_pkg::*;

    localparam int NREQ  = 3;
    localparam int GAP   = IDLE_GAP_MIN;
    localparam int SPI_T = 3;

    logic clk;
    logic rst;

    oled_spi_arbiter_if #(.NREQ(NREQ)) bus ();

    oled_spi_arbiter #(.NREQ(NREQ), .IDLE_GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic [23:0] data;
        logic [2:0]  dcm;
        logic [2:0]  exp_gnt;
        logic [7:0]  exp_data;
        logic        exp_dc;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] bdata [NREQ][128];
    logic       bdc   [NREQ];
    int         blen  [NREQ];
    int         bpos  [NREQ];
    int         spi_cnt;
    vec_t       vt    [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Requester model: present the byte at bpos while bpos < blen.
    task automatic present();
        logic [NREQ-1:0]   r, l, d;
        logic [8*NREQ-1:0] dt;
        r = '0; l = '0; d = '0; dt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bpos[i] < blen[i]) begin
                r[i]        = 1'b1;
                l[i]        = (bpos[i] == blen[i] - 1);
                d[i]        = bdc[i];
                dt[8*i +: 8] = bdata[i][bpos[i]];
            end
        end
        bus.req     = r;
        bus.last    = l;
        bus.dc_in   = d;
        bus.data_in = dt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst || !bus.spi_en) begin
            spi_cnt     = 0;
            bus.spi_fin = 1'b0;
        end else if (spi_cnt == SPI_T - 1) begin
            bus.spi_fin = 1'b1;
        end else begin
            spi_cnt++;
            bus.spi_fin = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bus.ack[i]) bpos[i]++;
        end
        present();
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) begin
            blen[i] = 0;
            bpos[i] = 0;
            bdc[i]  = 1'b0;
        end
        present();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_reqs();
        bus.spi_fin = 1'b0;
        spi_cnt     = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (bus.busy && n < 60) begin
            tick();
            n++;
        end
        chk(nm, 32'(n < 60), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int n;
        for (int i = 0; i < NREQ; i++) begin
            if (v.req[i]) begin
                blen[i]     = 1;
                bpos[i]     = 0;
                bdata[i][0] = v.data[8*i +: 8];
                bdc[i]      = v.dcm[i];
            end
        end
        present();
        tick();
        chk($sformatf("vec%0d_gnt", k),      32'(bus.gnt),      32'(v.exp_gnt));
        chk($sformatf("vec%0d_spi_en", k),   32'(bus.spi_en),   32'd1);
        chk($sformatf("vec%0d_data", k),     32'(bus.spi_data), 32'(v.exp_data));
        chk($sformatf("vec%0d_dc", k),       32'(bus.dc),       32'(v.exp_dc));
        chk($sformatf("vec%0d_busy", k),     32'(bus.busy),     32'd1);
        for (int i = 0; i < NREQ; i++) begin
            if (!v.exp_gnt[i]) blen[i] = 0;
        end
        present();
        n = 0;
        while (bus.spi_en && n < 20) begin
            tick();
            n++;
        end
        chk($sformatf("vec%0d_fin_wait", k), 32'(n < 20),       32'd1);
        chk($sformatf("vec%0d_ack", k),      32'(bus.ack),      32'(v.exp_gnt));
        chk($sformatf("vec%0d_gnt_gap1", k), 32'(bus.gnt),      32'(v.exp_gnt));
        tick();
        chk($sformatf("vec%0d_ack_once", k), 32'(bus.ack),      32'd0);
        chk($sformatf("vec%0d_gap2_en", k),  32'(bus.spi_en),   32'd0);
        chk($sformatf("vec%0d_gap2_busy", k), 32'(bus.busy),    32'd1);
        tick();
        chk($sformatf("vec%0d_release", k),  32'(bus.gnt),      32'd0);
        chk($sformatf("vec%0d_idle", k),     32'(bus.busy),     32'd0);
        chk($sformatf("vec%0d_data_hold", k), 32'(bus.spi_data), 32'(v.exp_data));
        chk($sformatf("vec%0d_dc_hold", k),  32'(bus.dc),       32'(v.exp_dc));
    endtask

    initial begin
        int         n, cyc, nbytes, n_ack, bad_gap, bad_dc, bad_data, low_run, wrong_gnt;
        logic       prev_en;
        logic [7:0] got [3];

        // Ptr sequence starting at 0: 0->1, 2->0, 0->1, 1->2, 0->1, 1->2, 2->0, 1->2, 0.
        vt[0] = '{3'b001, {8'h00, 8'h00, CMD_DISPLAY_OFF},       3'b000, 3'b001, CMD_DISPLAY_OFF, 1'b0};
        vt[1] = '{3'b101, {8'h3C, 8'h00, CMD_CHARGE_PUMP},       3'b100, 3'b100, 8'h3C,           1'b1};
        vt[2] = '{3'b011, {8'h00, 8'hA5, CMD_CHARGE_PUMP},       3'b010, 3'b001, CMD_CHARGE_PUMP, 1'b0};
        vt[3] = '{3'b011, {8'h00, CMD_CHARGE_PUMP_ON, 8'h77},    3'b011, 3'b010, CMD_CHARGE_PUMP_ON, 1'b1};
        vt[4] = '{3'b001, {8'h00, 8'h00, 8'hFF},                 3'b001, 3'b001, 8'hFF,           1'b1};
        vt[5] = '{3'b111, {8'h11, CMD_CONTRAST, 8'h33},          3'b000, 3'b010, CMD_CONTRAST,    1'b0};
        vt[6] = '{3'b111, {8'hC3, 8'h22, 8'h44},                 3'b100, 3'b100, 8'hC3,           1'b1};
        vt[7] = '{3'b110, {8'h99, 8'h00, 8'h55},                 3'b001, 3'b010, 8'h00,           1'b0};
        vt[8] = '{3'b001, {8'h00, 8'h00, CMD_DISPLAY_ON},        3'b000, 3'b001, CMD_DISPLAY_ON,  1'b0};

        do_reset();
        chk("rst_gnt",      32'(bus.gnt),      32'd0);
        chk("rst_ack",      32'(bus.ack),      32'd0);
        chk("rst_spi_en",   32'(bus.spi_en),   32'd0);
        chk("rst_spi_data", 32'(bus.spi_data), 32'd0);
        chk("rst_dc",       32'(bus.dc),       32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        tick();
        chk("idle_no_req_busy", 32'(bus.busy), 32'd0);

        for (int k = 0; k < 9; k++) run_vec(vt[k], k);

        // Requesters 0 and 2 together at ptr 0: 0 first, then 2.
        do_reset();
        blen[0] = 1; bdata[0][0] = CMD_DISPLAY_OFF; bdc[0] = 1'b0;
        blen[2] = 1; bdata[2][0] = 8'h40;           bdc[2] = 1'b1;
        present();
        tick();
        chk("pair_first_gnt",  32'(bus.gnt),      32'b001);
        chk("pair_first_data", 32'(bus.spi_data), 32'(CMD_DISPLAY_OFF));
        n = 0;
        wrong_gnt = 0;
        while (bus.gnt != 3'b100 && n < 30) begin
            if (bus.gnt == 3'b010) wrong_gnt++;
            tick();
            n++;
        end
        chk("pair_second_gnt",  32'(bus.gnt),      32'b100);
        chk("pair_no_req1",     32'(wrong_gnt),    32'd0);
        chk("pair_second_data", 32'(bus.spi_data), 32'h40);
        chk("pair_second_dc",   32'(bus.dc),       32'd1);
        wait_idle("pair_idle");

        // 3-byte burst from requester 1; requester 0 arrives mid-burst.
        blen[1] = 3; bpos[1] = 0; bdc[1] = 1'b0;
        bdata[1][0] = CMD_CONTRAST; bdata[1][1] = 8'h0F; bdata[1][2] = CMD_DISPLAY_ON;
        present();
        tick();
        chk("burst_gnt", 32'(bus.gnt), 32'b010);
        nbytes = 0; n_ack = 0; cyc = 0; prev_en = 1'b0;
        got[0] = 8'h00; got[1] = 8'h00; got[2] = 8'h00;
        while (bus.gnt == 3'b010 && cyc < 100) begin
            if (bus.spi_en && !prev_en) begin
                if (nbytes < 3) got[nbytes] = bus.spi_data;
                nbytes++;
            end
            if (bus.ack[1]) n_ack++;
            prev_en = bus.spi_en;
            if (cyc == 4) begin
                blen[0] = 1; bpos[0] = 0; bdata[0][0] = CMD_DISPLAY_ON; bdc[0] = 1'b0;
                present();
            end
            tick();
            cyc++;
        end
        chk("burst_nbytes", 32'(nbytes), 32'd3);
        chk("burst_acks",   32'(n_ack),  32'd3);
        chk("burst_b0",     32'(got[0]), 32'(CMD_CONTRAST));
        chk("burst_b1",     32'(got[1]), 32'h0F);
        chk("burst_b2",     32'(got[2]), 32'(CMD_DISPLAY_ON));
        chk("burst_release", 32'(bus.gnt), 32'd0);
        tick();
        chk("burst_then_req0", 32'(bus.gnt), 32'b001);
        wait_idle("burst_idle");

        // 128-byte data burst from requester 2.
        for (int j = 0; j < 128; j++) bdata[2][j] = 8'(j) ^ 8'h5A;
        blen[2] = 128; bpos[2] = 0; bdc[2] = 1'b1;
        present();
        tick();
        chk("frame_gnt", 32'(bus.gnt), 32'b100);
        nbytes = 0; n_ack = 0; bad_gap = 0; bad_dc = 0; bad_data = 0; low_run = 0;
        cyc = 0; prev_en = 1'b0;
        while (cyc < 2000) begin
            if (bus.spi_en && !prev_en) begin
                if (nbytes > 0 && low_run != GAP) bad_gap++;
                if (bus.spi_data !== (8'(nbytes) ^ 8'h5A)) bad_data++;
                nbytes++;
                low_run = 0;
            end
            if (!bus.spi_en) low_run++;
            if (bus.spi_en && !bus.dc) bad_dc++;
            if (bus.ack[2]) n_ack++;
            prev_en = bus.spi_en;
            if (bus.gnt == 3'b000) break;
            tick();
            cyc++;
        end
        chk("frame_done",     32'(cyc < 2000), 32'd1);
        chk("frame_nbytes",   32'(nbytes),     32'd128);
        chk("frame_acks",     32'(n_ack),      32'd128);
        chk("frame_gap_len",  32'(bad_gap),    32'd0);
        chk("frame_dc",       32'(bad_dc),     32'd0);
        chk("frame_data",     32'(bad_data),   32'd0);
        chk("frame_dc_hold",  32'(bus.dc),     32'd1);

        // Owner drops req during SEND with last = 0.
        blen[1] = 3; bpos[1] = 0; bdc[1] = 1'b0;
        bdata[1][0] = 8'h10; bdata[1][1] = 8'h20; bdata[1][2] = 8'h30;
        present();
        tick();
        chk("drop_gnt", 32'(bus.gnt), 32'b010);
        blen[1] = 0;
        present();
        tick();
        chk("drop_no_abort", 32'(bus.spi_en), 32'd1);
        n = 0;
        while (bus.spi_en && n < 20) begin
            tick();
            n++;
        end
        chk("drop_ack",  32'(bus.ack), 32'b010);
        tick();
        tick();
        chk("drop_release", 32'(bus.gnt),      32'd0);
        chk("drop_idle",    32'(bus.busy),     32'd0);
        chk("drop_hold",    32'(bus.spi_data), 32'h10);

        // Reset during SEND; ptr was 2 before reset, must restart at 0.
        blen[2] = 1; bpos[2] = 0; bdata[2][0] = 8'h66; bdc[2] = 1'b1;
        present();
        tick();
        chk("rstsend_gnt", 32'(bus.gnt), 32'b100);
        rst = 1'b1;
        #1;
        chk("rstsend_spi_en", 32'(bus.spi_en), 32'd0);
        chk("rstsend_gnt0",   32'(bus.gnt),    32'd0);
        chk("rstsend_ack",    32'(bus.ack),    32'd0);
        chk("rstsend_busy",   32'(bus.busy),   32'd0);
        clear_reqs();
        bus.spi_fin = 1'b0;
        spi_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        blen[1] = 1; bdata[1][0] = 8'h71; bdc[1] = 1'b0;
        blen[2] = 1; bdata[2][0] = 8'h72; bdc[2] = 1'b1;
        present();
        tick();
        chk("rstsend_ptr0_gnt",  32'(bus.gnt),      32'b010);
        chk("rstsend_ptr0_data", 32'(bus.spi_data), 32'h71);
        wait_idle("rstsend_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oled_spi_arbiter.md
# oled_spi_arbiter

Shares the single SpiCtrl byte engine of the OLED subsystem between several requesters: the power-up init sequencer, the page/frame writer and a runtime command port (contrast, display on/off). Grants are round-robin and held for a whole burst, so one requester's command sequence never interleaves with another's. The block drives SpiCtrl's enable/data handshake and the SSD1306 D/C line for the granted requester.

## Interface
- NREQ, 3, number of requesters (2..8); index 0 is the init sequencer.
- IDLE_GAP, 2, cycles spi_en is held low between consecutive bytes (legal range 2..15).
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NREQ  per-requester request; held high while a byte is pending.
- last  in  NREQ  byte presented is the final byte of the requester's burst.
- dc_in  in  NREQ  D/C value for the presented byte (0 = command, 1 = data).
- data_in  in  8*NREQ  byte per requester; requester i occupies bits [8i+7:8i].
- gnt  out  NREQ  one-hot grant; all zero when idle.
- ack  out  NREQ  one-cycle pulse: the granted requester's byte has been shifted out.
- spi_en  out  1  to SpiCtrl SPI_EN.
- spi_data  out  8  to SpiCtrl SPI_DATA.
- spi_fin  in  1  from SpiCtrl SPI_FIN.
- dc  out  1  OLED D/C pin.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SEND, GAP.
- IDLE: if any req is high, select winner g with a round-robin search starting at ptr (ptr = 0 after reset, wrapping modulo NREQ). On the clock edge set gnt[g], latch spi_data <= data_in[g] and dc <= dc_in[g], capture last[g] into last_q, then go to SEND.
- SEND: spi_en = 1. When spi_fin = 1, go to GAP and pulse ack[g] in the first GAP cycle.
- GAP: spi_en = 0 for IDLE_GAP cycles, counted by gap_cnt. On the final GAP cycle:
  - If last_q = 1 or req[g] = 0: clear gnt, set ptr <= (g+1) mod NREQ, go to IDLE.
  - Otherwise: latch the next byte from requester g (data, dc, last) and go to SEND.
- Requester contract: on the edge where ack is high, the requester either advances to its next byte or drops req. No requester other than g can preempt a burst.
- spi_fin is ignored outside SEND.
- A req that drops during SEND does not abort the byte in flight. It only takes effect at the end of GAP.
- dc and spi_data hold their values through GAP and IDLE. They change only when a byte is latched.

## Timing
- Reset values: gnt = 0, ack = 0, spi_en = 0, spi_data = 8'h00, dc = 0, busy = 0, ptr = 0, state = IDLE.
- Reset mid-operation clears everything immediately. SpiCtrl shares rst, so no partial byte resumes.
- Latency from req rising in IDLE to spi_en = 1: 1 cycle.
- Per byte: SPI time + 1 cycle to observe spi_fin + IDLE_GAP cycles.
- Simultaneous requests in IDLE: the first index at or above ptr wins, with wrap-around.
- A single requester with a 1-byte burst (last = 1) releases after one GAP and can re-win the following IDLE cycle only if no other requester is pending at or after ptr.

## Structure
- Shared package oled_pkg holds:
  - the arb_state_e enum (IDLE, SEND, GAP);
  - SSD1306 command constants (display off 8'hAE, on 8'hAF, charge pump 8'h8D/8'h14, contrast 8'h81);
  - the IDLE_GAP minimum.
- One sub-module, rr_pick: combinational round-robin picker with inputs req and ptr and outputs the one-hot winner and its index.
- SpiCtrl is instantiated by the parent, not inside this block.

## Test plan
- Reset, then req = 3'b001 with a 1-byte burst data 8'hAE, dc = 0:
  - gnt = 001 after 1 cycle; spi_data = AE, spi_en = 1 until fin;
  - ack[0] fires once; gnt returns to 0 after 2 GAP cycles.
- Requesters 0 and 2 request together at ptr = 0:
  - requester 0 is served first;
  - after release ptr = 1, and requester 2 is granted next.
- Requester 1 sends a 3-byte burst (8'h81, 8'h0F, 8'hAF) while requester 0 raises req mid-burst:
  - all three bytes go out consecutively with gnt = 010 held;
  - gnt changes to 001 only afterwards.
- Data burst of 128 bytes with dc = 1 and last set on byte 128:
  - 128 ack pulses, dc = 1 throughout, spi_en low for exactly 2 cycles between bytes.
- Granted requester drops req during SEND:
  - the byte completes and ack pulses;
  - the grant is released at the end of GAP even though last = 0.
- Assert rst during SEND:
  - spi_en, gnt, ack and busy go to 0 in the same cycle;
  - after reset release, a new request starts from ptr = 0.
